lcd_cgram_readback: RTL and testbench

//  Reader side of the HD44780 4-bit LCD bus: reads back one 5x8 custom glyph from CGRAM.

---
 rtl/lcd_cgram_readback.sv | 260 ++++++++++++++++++++++++++
 tb/tb_lcd_cgram_readback.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cgram_readback.sv
// ---------------------------------------------------------------------------
// lcd_cgram_readback
//   Reads one 5x8 custom glyph back out of HD44780 CGRAM over the 4-bit bus.
//   The sequence is: set the CGRAM address (cmd 0x40 | idx<<3) as two nibbles,
//   poll the busy flag until it clears, then read 8 rows as nibble pairs with
//   RS=1/RW=1. The panel's address counter auto-increments, so rows are read
//   back-to-back without re-addressing. Each row is presented on a row_valid
//   strobe.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             request a readback (sampled only while idle)
//   char_idx[2:0]     CGRAM character slot to read
//   data_i[3:0]       DB7..DB4 as driven by the panel
//   rs, rw, e         LCD control lines
//   data_o[3:0]       DB7..DB4 driven by this block
//   data_oe           1 = drive data_o, 0 = release the bus
//   busy              high from accepted start until done/error
//   row_valid         one-clk strobe qualifying row_idx/row_data
//   row_idx[2:0]      row number of row_data
//   row_data[4:0]     glyph row bits
//   done              one-clk pulse after all 8 rows
//   error             one-clk pulse on busy-flag timeout
// ---------------------------------------------------------------------------
module lcd_cgram_readback #(
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned BUSY_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] char_idx,
    input  logic [3:0] data_i,
    output logic       rs,
    output logic       rw,
    output logic       e,
    output logic [3:0] data_o,
    output logic       data_oe,
    output logic       busy,
    output logic       row_valid,
    output logic [2:0] row_idx,
    output logic [4:0] row_data,
    output logic       done,
    output logic       error
);

    localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned POLL_W = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_POLL_HI,
        S_POLL_LO,
        S_RD_HI,
        S_RD_LO,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q,     state_d;
    logic [DIV_W-1:0]    div_q,       div_d;
    logic [1:0]          phase_q,     phase_d;
    logic [2:0]          idx_q,       idx_d;
    logic [POLL_W-1:0]   poll_q,      poll_d;
    logic                bf_q,        bf_d;
    logic                bit4_q,      bit4_d;
    logic [3:0]          lo_q,        lo_d;
    logic                rs_q,        rs_d;
    logic                rw_q,        rw_d;
    logic                e_q,         e_d;
    logic [3:0]          data_o_q,    data_o_d;
    logic                data_oe_q,   data_oe_d;
    logic                busy_q,      busy_d;
    logic                row_valid_q, row_valid_d;
    logic [2:0]          row_idx_q,   row_idx_d;
    logic [4:0]          row_data_q,  row_data_d;
    logic                done_q,      done_d;
    logic                error_q,     error_d;

    logic in_xfer_c;
    logic tick_c;
    logic sample_c;
    logic last_c;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            phase_q     <= '0;
            idx_q       <= '0;
            poll_q      <= '0;
            bf_q        <= 1'b0;
            bit4_q      <= 1'b0;
            lo_q        <= '0;
            rs_q        <= 1'b0;
            rw_q        <= 1'b0;
            e_q         <= 1'b0;
            data_o_q    <= '0;
            data_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            row_valid_q <= 1'b0;
            row_idx_q   <= '0;
            row_data_q  <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            phase_q     <= phase_d;
            idx_q       <= idx_d;
            poll_q      <= poll_d;
            bf_q        <= bf_d;
            bit4_q      <= bit4_d;
            lo_q        <= lo_d;
            rs_q        <= rs_d;
            rw_q        <= rw_d;
            e_q         <= e_d;
            data_o_q    <= data_o_d;
            data_oe_q   <= data_oe_d;
            busy_q      <= busy_d;
            row_valid_q <= row_valid_d;
            row_idx_q   <= row_idx_d;
            row_data_q  <= row_data_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    // Tick timing: a transfer is four ticks (phase 0..3), e high in phases 1 and 2
    always_comb begin
        in_xfer_c = (state_q == S_ADDR_HI) || (state_q == S_ADDR_LO) ||
                    (state_q == S_POLL_HI) || (state_q == S_POLL_LO) ||
                    (state_q == S_RD_HI)   || (state_q == S_RD_LO);
        tick_c    = in_xfer_c && (div_q == DIV_W'(CLK_DIV - 1));
        sample_c  = tick_c && (phase_q == 2'd2);
        last_c    = tick_c && (phase_q == 2'd3);
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        div_d       = '0;
        phase_d     = '0;
        idx_d       = idx_q;
        poll_d      = poll_q;
        bf_d        = bf_q;
        bit4_d      = bit4_q;
        lo_d        = lo_q;
        rs_d        = 1'b0;
        rw_d        = 1'b0;
        e_d         = 1'b0;
        data_o_d    = '0;
        data_oe_d   = 1'b0;
        busy_d      = busy_q;
        row_valid_d = 1'b0;
        row_idx_d   = row_idx_q;
        row_data_d  = row_data_q;
        done_d      = 1'b0;
        error_d     = 1'b0;

        if (in_xfer_c) begin
            div_d   = tick_c ? '0 : div_q + DIV_W'(1);
            phase_d = tick_c ? phase_q + 2'd1 : phase_q;
            e_d     = (phase_q == 2'd1) || (phase_q == 2'd2);
        end

        // Row index advances the clock after each strobe; wraps to 0 after row 7
        if (row_valid_q) begin
            row_idx_d = row_idx_q + 3'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_ADDR_HI;
                    idx_d     = char_idx;
                    busy_d    = 1'b1;
                    poll_d    = '0;
                    row_idx_d = '0;
                end
            end
            S_ADDR_HI: begin
                data_oe_d = 1'b1;
                data_o_d  = {2'b01, idx_q[2:1]};
                if (last_c) state_d = S_ADDR_LO;
            end
            S_ADDR_LO: begin
                data_oe_d = 1'b1;
                data_o_d  = {idx_q[0], 3'b000};
                if (last_c) state_d = S_POLL_HI;
            end
            S_POLL_HI: begin
                rw_d = 1'b1;
                if (sample_c) bf_d = data_i[3];
                if (last_c) state_d = S_POLL_LO;
            end
            S_POLL_LO: begin
                // Low nibble is the address counter; only BF from the high nibble matters
                rw_d = 1'b1;
                if (last_c) begin
                    poll_d = poll_q + POLL_W'(1);
                    if (!bf_q) begin
                        state_d = S_RD_HI;
                    end else if ((poll_q + POLL_W'(1)) < POLL_W'(BUSY_TIMEOUT)) begin
                        state_d = S_POLL_HI;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_RD_HI: begin
                rs_d = 1'b1;
                rw_d = 1'b1;
                if (sample_c) bit4_d = data_i[0];
                if (last_c) state_d = S_RD_LO;
            end
            S_RD_LO: begin
                rs_d = 1'b1;
                rw_d = 1'b1;
                if (sample_c) lo_d = data_i;
                if (last_c) begin
                    row_valid_d = 1'b1;
                    row_data_d  = {bit4_q, lo_q};
                    state_d     = (row_idx_q == 3'd7) ? S_DONE : S_RD_HI;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_ERR: begin
                error_d   = 1'b1;
                busy_d    = 1'b0;
                row_idx_d = '0;
                state_d   = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign rs        = rs_q;
    assign rw        = rw_q;
    assign e         = e_q;
    assign data_o    = data_o_q;
    assign data_oe   = data_oe_q;
    assign busy      = busy_q;
    assign row_valid = row_valid_q;
    assign row_idx   = row_idx_q;
    assign row_data  = row_data_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_lcd_cgram_readback.sv
// ---------------------------------------------------------------------------
// tb_lcd_cgram_readback
//   Directed bench for lcd_cgram_readback with a small HD44780 panel model
//   answering busy-flag and CGRAM reads, plus a bus monitor.
// ---------------------------------------------------------------------------
module tb_lcd_cgram_readback;

    localparam int unsigned CD = 4;
    localparam int unsigned BT = 4;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       start    = 1'b0;
    logic [2:0] char_idx = 3'd0;
    logic [3:0] data_i   = 4'd0;
    logic       rs, rw, e, data_oe, busy, row_valid, done, error;
    logic [3:0] data_o;
    logic [2:0] row_idx;
    logic [4:0] row_data;

    lcd_cgram_readback #(.CLK_DIV(CD), .BUSY_TIMEOUT(BT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .char_idx(char_idx),
        .data_i(data_i), .rs(rs), .rw(rw), .e(e), .data_o(data_o),
        .data_oe(data_oe), .busy(busy), .row_valid(row_valid),
        .row_idx(row_idx), .row_data(row_data), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Panel model configuration (written by the stimulus block only)
    logic [4:0] rows [8];
    int         bf_ones  = 0;
    bit         bf_stuck = 1'b0;

    // Panel model state (written by the model only)
    int         poll_n    = 0;
    int         last_kind = 0;   // 0 write, 1 poll hi, 2 poll lo, 3 rd hi, 4 rd lo
    bit         poll_lo   = 1'b0;
    bit         row_lo    = 1'b0;
    logic [2:0] row_ptr   = 3'd0;

    initial begin
        forever begin
            @(posedge e);
            if (!rw) begin
                poll_lo   = 1'b0;
                row_lo    = 1'b0;
                row_ptr   = 3'd0;
                poll_n    = 0;
                data_i    = 4'h0;
                last_kind = 0;
            end else if (!rs) begin
                if (!poll_lo) begin
                    data_i    = {(bf_stuck || (poll_n < bf_ones)), 3'b010};
                    last_kind = 1;
                end else begin
                    data_i    = 4'b1011;
                    poll_n    = poll_n + 1;
                    last_kind = 2;
                end
                poll_lo = !poll_lo;
            end else begin
                if (!row_lo) begin
                    data_i    = {3'b101, rows[row_ptr][4]};
                    last_kind = 3;
                end else begin
                    data_i    = rows[row_ptr][3:0];
                    row_ptr   = row_ptr + 3'd1;
                    last_kind = 4;
                end
                row_lo = !row_lo;
            end
        end
    end

    // Bus / output monitor
    int         bus_viol = 0, e_viol = 0, n_xfer = 0, ehigh = 0;
    int         n_rows = 0, n_done = 0, n_err = 0, n_wr = 0;
    int         done_cyc = 0, err_cyc = 0;
    logic [4:0] rv_data [64];
    logic [2:0] rv_idx  [64];
    logic [3:0] wr_nib  [64];

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ehigh = 0;
            end else begin
                if (rw && data_oe) bus_viol = bus_viol + 1;
                if (e && !rw && !data_oe) bus_viol = bus_viol + 1;
                if (e) begin
                    if (ehigh == 0 && !rw) begin
                        wr_nib[n_wr % 64] = data_o;
                        n_wr = n_wr + 1;
                    end
                    ehigh = ehigh + 1;
                end else if (ehigh != 0) begin
                    if (ehigh != 2 * CD) e_viol = e_viol + 1;
                    n_xfer = n_xfer + 1;
                    ehigh  = 0;
                end
                if (row_valid) begin
                    rv_data[n_rows % 64] = row_data;
                    rv_idx[n_rows % 64]  = row_idx;
                    n_rows = n_rows + 1;
                end
                if (done) begin
                    n_done   = n_done + 1;
                    done_cyc = cyc;
                end
                if (error) begin
                    n_err   = n_err + 1;
                    err_cyc = cyc;
                end
            end
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [2:0] idx, output int c0);
        @(negedge clk);
        char_idx = idx;
        start    = 1'b1;
        c0       = int'(cyc);
        @(negedge clk);
        start    = 1'b0;
        char_idx = ~idx;
    endtask

    task automatic wait_end(input int d0, input int e0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (n_done != d0 || n_err != e0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_rows(input string tag, input int r0);
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_data"}, 32'(rv_data[(r0 + i) % 64]), 32'(rows[i]));
            chk({tag, "_idx"},  32'(rv_idx[(r0 + i) % 64]),  32'(i));
        end
    endtask

    initial begin
        int c0, d0, e0, r0, w0, x0;
        bit ok;
        bit found;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            32'({rs, rw, e, data_o, data_oe, busy, row_valid, row_idx, row_data, done, error}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic readback, idx=3, BF clear on first poll
        rows = '{5'h00, 5'h0E, 5'h0E, 5'h0E, 5'h0E, 5'h0E, 5'h0E, 5'h00};
        bf_ones = 0;
        d0 = n_done; e0 = n_err; r0 = n_rows; w0 = n_wr; x0 = n_xfer;
        start_run(3'd3, c0);
        chk("t2_busy_after_start", 32'(busy), 32'd1);
        wait_end(d0, e0, ok);
        chk("t2_finished", 32'(ok), 32'd1);
        chk("t2_done_count", 32'(n_done - d0), 32'd1);
        chk("t2_err_count", 32'(n_err - e0), 32'd0);
        chk("t2_done_latency", 32'(done_cyc - c0 - 1), 32'd321);
        chk("t2_busy_at_done", 32'(busy), 32'd0);
        chk("t2_rows", 32'(n_rows - r0), 32'd8);
        chk("t2_wr_count", 32'(n_wr - w0), 32'd2);
        chk("t2_addr_hi", 32'(wr_nib[w0 % 64]), 32'h5);
        chk("t2_addr_lo", 32'(wr_nib[(w0 + 1) % 64]), 32'h8);
        chk("t2_xfers", 32'(n_xfer - x0), 32'd20);
        check_rows("t2_row", r0);
        chk("t2_row_idx_wrap", 32'(row_idx), 32'd0);
        chk("t2_row_data_hold", 32'(row_data), 32'h00);

        // Three BF=1 polls before clear
        rows = '{5'h1F, 5'h11, 5'h0A, 5'h04, 5'h15, 5'h00, 5'h1B, 5'h10};
        bf_ones = 3;
        d0 = n_done; e0 = n_err; r0 = n_rows; w0 = n_wr; x0 = n_xfer;
        start_run(3'd5, c0);
        wait_end(d0, e0, ok);
        chk("t3_finished", 32'(ok), 32'd1);
        chk("t3_done_count", 32'(n_done - d0), 32'd1);
        chk("t3_err_count", 32'(n_err - e0), 32'd0);
        chk("t3_done_latency", 32'(done_cyc - c0 - 1), 32'd417);
        chk("t3_polls", 32'(poll_n), 32'd4);
        chk("t3_addr_hi", 32'(wr_nib[w0 % 64]), 32'h6);
        chk("t3_addr_lo", 32'(wr_nib[(w0 + 1) % 64]), 32'h8);
        chk("t3_xfers", 32'(n_xfer - x0), 32'd26);
        chk("t3_rows", 32'(n_rows - r0), 32'd8);
        check_rows("t3_row", r0);
        bf_ones = 0;

        // BF stuck high -> timeout after BT polls
        bf_stuck = 1'b1;
        d0 = n_done; e0 = n_err; r0 = n_rows; w0 = n_wr; x0 = n_xfer;
        start_run(3'd6, c0);
        wait_end(d0, e0, ok);
        chk("t4_finished", 32'(ok), 32'd1);
        chk("t4_err_count", 32'(n_err - e0), 32'd1);
        chk("t4_done_count", 32'(n_done - d0), 32'd0);
        chk("t4_err_latency", 32'(err_cyc - c0 - 1), 32'd161);
        chk("t4_polls", 32'(poll_n), 32'd4);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_row_idx", 32'(row_idx), 32'd0);
        chk("t4_rows", 32'(n_rows - r0), 32'd0);
        chk("t4_addr_hi", 32'(wr_nib[w0 % 64]), 32'h7);
        chk("t4_addr_lo", 32'(wr_nib[(w0 + 1) % 64]), 32'h0);
        chk("t4_xfers", 32'(n_xfer - x0), 32'd10);
        bf_stuck = 1'b0;
        repeat (4) @(negedge clk);

        // start re-pulsed during RD_HI is ignored
        rows = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h03, 5'h0C, 5'h18};
        d0 = n_done; e0 = n_err; r0 = n_rows; w0 = n_wr;
        start_run(3'd1, c0);
        found = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (e && rs && last_kind == 3) begin
                found = 1'b1;
                break;
            end
        end
        chk("t5_reached_rd_hi", 32'(found), 32'd1);
        start    = 1'b1;
        char_idx = 3'd4;
        @(negedge clk);
        start    = 1'b0;
        wait_end(d0, e0, ok);
        chk("t5_finished", 32'(ok), 32'd1);
        chk("t5_done_latency", 32'(done_cyc - c0 - 1), 32'd321);
        repeat (200) @(negedge clk);
        chk("t5_done_count", 32'(n_done - d0), 32'd1);
        chk("t5_rows", 32'(n_rows - r0), 32'd8);
        chk("t5_wr_count", 32'(n_wr - w0), 32'd2);
        chk("t5_addr_hi", 32'(wr_nib[w0 % 64]), 32'h4);
        chk("t5_addr_lo", 32'(wr_nib[(w0 + 1) % 64]), 32'h8);
        chk("t5_busy_idle", 32'(busy), 32'd0);
        check_rows("t5_row", r0);

        // Reset asserted mid-RD_LO with e high
        d0 = n_done; e0 = n_err; r0 = n_rows;
        start_run(3'd2, c0);
        found = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (e && rs && last_kind == 4) begin
                found = 1'b1;
                break;
            end
        end
        chk("t1_reached_rd_lo", 32'(found), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_e_drop", 32'(e), 32'd0);
        chk("t1_reset_outputs",
            32'({rs, rw, e, data_o, data_oe, busy, row_valid, row_idx, row_data, done, error}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (400) @(negedge clk);
        chk("t1_no_done", 32'(n_done - d0), 32'd0);
        chk("t1_no_err", 32'(n_err - e0), 32'd0);
        chk("t1_no_rows", 32'(n_rows - r0), 32'd0);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // Recovery run after reset, idx=0
        rows = '{5'h1F, 5'h00, 5'h1F, 5'h00, 5'h1F, 5'h00, 5'h1F, 5'h00};
        d0 = n_done; e0 = n_err; r0 = n_rows; w0 = n_wr;
        start_run(3'd0, c0);
        wait_end(d0, e0, ok);
        chk("t7_finished", 32'(ok), 32'd1);
        chk("t7_done_latency", 32'(done_cyc - c0 - 1), 32'd321);
        chk("t7_addr_hi", 32'(wr_nib[w0 % 64]), 32'h4);
        chk("t7_addr_lo", 32'(wr_nib[(w0 + 1) % 64]), 32'h0);
        check_rows("t7_row", r0);

        // Bus discipline across every transfer of every run
        chk("bus_oe_vs_rw", 32'(bus_viol), 32'd0);
        chk("bus_e_width", 32'(e_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
